// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store unit between the pipeline and a simple
// ack-handshake memory port. Handles byte/halfword/word lane selection and
// store-data replication. Load data comes back right-justified and zero-filled.
// Each access is bounded by a timeout that returns an error response.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, misaligned
// halfword/word requests return an error without touching memory. When it is
// undefined, the offending low address bits are dropped.
module memory_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic [1:0]  resp_size,
   output logic        resp_error,
   output logic        stall
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             cap_write;
   logic [1:0]       cap_size;
   logic [1:0]       cap_off;
   logic [1:0]       req_off;

   // Offset actually used for lane selection; the sub-size bits are dropped
   // so a misaligned access degrades to its naturally aligned container.
   function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd2:    return off;
         2'd1:    return {off[1], 1'b0};
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd2:    return 4'b0001 << off;
         2'd1:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'd2:    return {4{wdata[7:0]}};
         2'd1:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] align_load(input logic [1:0] size, input logic [1:0] off,
                                              input logic [31:0] rdata);
      logic [31:0] shifted;
      shifted = rdata >> {off, 3'b000};
      case (size)
         2'd2:    return {24'd0, shifted[7:0]};
         2'd1:    return {16'd0, shifted[15:0]};
         default: return shifted;
      endcase
   endfunction

`ifdef MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd2:    return 1'b0;
         2'd1:    return off[0];
         default: return off != 2'b00;
      endcase
   endfunction
`endif

   assign req_off   = eff_offset(req_size, req_addr[1:0]);
   assign req_ready = (state == IDLE);
   assign stall     = (state != IDLE);

   // Request/response FSM with registered memory-side and response outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cap_write  <= 1'b0;
         cap_size   <= 2'd0;
         cap_off    <= 2'd0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_be     <= 4'b0000;
         mem_wdata  <= 32'd0;
         resp_valid <= 1'b0;
         resp_error <= 1'b0;
         resp_data  <= 32'd0;
         resp_size  <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  cap_write <= req_write;
                  cap_size  <= req_size;
                  cap_off   <= req_off;
                  cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
                  if (misaligned(req_size, req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                     resp_data  <= 32'd0;
                     resp_size  <= req_size;
                  end else
`endif
                  begin
                     state     <= ACCESS;
                     mem_en    <= 1'b1;
                     mem_we    <= req_write;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= lane_enable(req_size, req_off);
                     mem_wdata <= replicate_store(req_size, req_wdata);
                  end
               end
            end
            ACCESS: begin
               // An ack in the last allowed cycle wins over the timeout.
               if (mem_ack || (cnt == CNT_LAST)) begin
                  state      <= RESP;
                  mem_en     <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_be     <= 4'b0000;
                  resp_valid <= 1'b1;
                  resp_size  <= cap_size;
                  resp_error <= !mem_ack;
                  if (mem_ack && !cap_write)
                     resp_data <= align_load(cap_size, cap_off, mem_rdata);
                  else
                     resp_data <= 32'd0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed bench for memory_access_unit with a response
// scoreboard. Expected responses are queued when a request is issued and
// compared when resp_valid is seen. Follows MISALIGN_TRAP_EN like the design.
module tb_memory_access_unit;

   localparam int TMO = 16;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_size;
   logic        resp_error;
   logic        stall;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
      logic [1:0]  size;
   } resp_t;

   resp_t exp_q[$];
   resp_t mon_e;
   int    checks = 0;
   int    errors = 0;

   memory_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_size   (req_size),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_size  (resp_size),
      .resp_error (resp_error),
      .stall      (stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every response pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (reset_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_resp", resp_valid, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_data", resp_data, mon_e.data);
            chk("resp_error", resp_error, mon_e.err);
            chk("resp_size", resp_size, mon_e.size);
         end
      end
   end

   // Issue one request and serve it; ack_cyc < 0 means never acknowledge.
   task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_cyc,
                          input logic [3:0] exp_be, input logic [31:0] exp_mwdata,
                          input logic [31:0] exp_maddr, input logic [31:0] exp_rdata,
                          input logic exp_err);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_size  = size;
      req_wdata = wdata;
      exp_q.push_back('{data: exp_rdata, err: exp_err, size: size});
      @(negedge clock);
      req_valid = 1'b0;
      req_wdata = 32'h0;
      for (int i = 0; i < TMO; i++) begin
         chk({tag, "_mem_en"}, mem_en, 1'b1);
         chk({tag, "_mem_be"}, mem_be, exp_be);
         if (i == 0) begin
            chk({tag, "_mem_we"}, mem_we, wr);
            chk({tag, "_mem_addr"}, mem_addr, exp_maddr);
            chk({tag, "_mem_wdata"}, mem_wdata, exp_mwdata);
            chk({tag, "_stall"}, stall, 1'b1);
            chk({tag, "_req_ready"}, req_ready, 1'b0);
         end
         if (i == ack_cyc) begin
            mem_ack   = 1'b1;
            mem_rdata = rdata;
         end
         @(negedge clock);
         if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_0000;
            break;
         end
      end
      chk({tag, "_resp_valid"}, resp_valid, 1'b1);
      chk({tag, "_mem_en_off"}, mem_en, 1'b0);
      @(negedge clock);
      chk({tag, "_resp_pulse"}, resp_valid, 1'b0);
      chk({tag, "_idle_ready"}, req_ready, 1'b1);
      chk({tag, "_idle_stall"}, stall, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_size  = 2'd0;
      req_wdata = 32'h0;
      mem_rdata = 32'h0;
      mem_ack   = 1'b0;
      #12;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_stall", stall, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_be", mem_be, 4'b0000);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_error", resp_error, 1'b0);
      chk("rst_resp_data", resp_data, 32'h0);
      chk("rst_resp_size", resp_size, 2'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // Byte load, upper lane, ack in the first ACCESS cycle.
      run_req("ldb_103", 1'b0, 32'h0000_0103, 2'd2, 32'h0, 32'hA1B2_C3D4, 0,
              4'b1000, 32'h0, 32'h0000_0100, 32'h0000_00A1, 1'b0);
      // Halfword store, upper half, ack after two wait cycles.
      run_req("sth_202", 1'b1, 32'h0000_0202, 2'd1, 32'h0000_BEEF, 32'hFFFF_FFFF, 2,
              4'b1100, 32'hBEEF_BEEF, 32'h0000_0200, 32'h0, 1'b0);
      // Halfword load, lower half.
      run_req("ldh_010", 1'b0, 32'h0000_0010, 2'd1, 32'h0, 32'hCAFE_F00D, 1,
              4'b0011, 32'h0, 32'h0000_0010, 32'h0000_F00D, 1'b0);
      // Byte store replicates only the low byte.
      run_req("stb_041", 1'b1, 32'h0000_0041, 2'd2, 32'h1234_565A, 32'h0, 0,
              4'b0010, 32'h5A5A_5A5A, 32'h0000_0040, 32'h0, 1'b0);
      // Size 3 behaves as a word load.
      run_req("ldw_s3", 1'b0, 32'h0000_0084, 2'd3, 32'h0, 32'h8765_4321, 0,
              4'b1111, 32'h0, 32'h0000_0084, 32'h8765_4321, 1'b0);
      // Ack in the final allowed cycle beats the timeout.
      run_req("ldw_lastack", 1'b0, 32'h0000_0050, 2'd0, 32'h0, 32'h0BAD_F00D, TMO - 1,
              4'b1111, 32'h0, 32'h0000_0050, 32'h0BAD_F00D, 1'b0);
      // No ack at all: timeout error with zero data.
      run_req("ldw_tmo", 1'b0, 32'h0000_0060, 2'd0, 32'h0, 32'h5555_AAAA, -1,
              4'b1111, 32'h0, 32'h0000_0060, 32'h0, 1'b1);

      // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0301;
      req_size  = 2'd0;
      exp_q.push_back('{data: 32'h0, err: 1'b1, size: 2'd0});
      @(negedge clock);
      req_valid = 1'b0;
      chk("trap_resp_valid", resp_valid, 1'b1);
      chk("trap_mem_en", mem_en, 1'b0);
      @(negedge clock);
      chk("trap_mem_en2", mem_en, 1'b0);
      chk("trap_idle_ready", req_ready, 1'b1);
`else
      run_req("ldw_301", 1'b0, 32'h0000_0301, 2'd0, 32'h0, 32'h1122_3344, 0,
              4'b1111, 32'h0, 32'h0000_0300, 32'h1122_3344, 1'b0);
`endif

      // Ack while idle must be ignored.
      mem_ack   = 1'b1;
      mem_rdata = 32'h9999_9999;
      @(negedge clock);
      chk("idle_ack_mem_en", mem_en, 1'b0);
      chk("idle_ack_stall", stall, 1'b0);
      @(negedge clock);
      mem_ack = 1'b0;
      chk("idle_ack_resp", resp_valid, 1'b0);

      // Reset in the middle of an access aborts it without a response.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0400;
      req_size  = 2'd0;
      req_wdata = 32'hABCD_0123;
      @(negedge clock);
      req_valid = 1'b0;
      chk("abort_mem_en_before", mem_en, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_mem_en", mem_en, 1'b0);
      chk("abort_mem_we", mem_we, 1'b0);
      chk("abort_mem_be", mem_be, 4'b0000);
      chk("abort_stall", stall, 1'b0);
      chk("abort_resp_valid", resp_valid, 1'b0);
      @(negedge clock);
      mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
      reset_n = 1'b1;
      @(negedge clock);
      chk("abort_ready_after", req_ready, 1'b1);
      chk("abort_no_resp", resp_valid, 1'b0);
      repeat (3) @(negedge clock);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum ACCESS cycles to wait for mem_ack before an error response.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the pipeline request ports, all inputs:
- req_valid, 1 bit: request present.
- req_write, 1 bit: 1 for store, 0 for load.
- req_addr, 32 bits: byte address.
- req_size, 2 bits: 0 word, 1 halfword, 2 byte; 3 treated as word.
- req_wdata, 32 bits: store data, right-justified.
REQ-005 The block SHALL have port req_ready, output, 1 bit: high when a request can be accepted this cycle.
REQ-006 The block SHALL have the memory-side outputs:
- mem_en, 1 bit: access strobe.
- mem_we, 1 bit: write strobe.
- mem_addr, 32 bits: word-aligned address.
- mem_be, 4 bits: byte-lane enables.
- mem_wdata, 32 bits: lane-replicated store data.
REQ-007 The block SHALL have the memory-side inputs:
- mem_rdata, 32 bits: read word.
- mem_ack, 1 bit: access complete.
REQ-008 The block SHALL have the response outputs:
- resp_valid, 1 bit: response pulse.
- resp_data, 32 bits: load data, right-justified and zero-filled above the access size, ready for the sign-extension stage.
- resp_size, 2 bits: echo of the captured req_size.
- resp_error, 1 bit: timeout, or misalignment when MISALIGN_TRAP_EN is defined.
REQ-009 The block SHALL have port stall, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 The FSM SHALL have the states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-011 In IDLE with req_valid=1, the block SHALL capture write, addr, size and wdata, clear the timeout counter, and move to ACCESS on the next edge.
REQ-012 In ACCESS, the block SHALL hold mem_en=1 and mem_we=captured write, with mem_addr={addr[31:2],2'b00}, mem_be and mem_wdata all stable, until mem_ack is sampled high.
REQ-013 When mem_ack=1 in ACCESS, the block SHALL register the aligned load data and go to RESP; loads SHALL have one-cycle response latency after the ack cycle.
REQ-014 When the counter reaches TIMEOUT_CYCLES without mem_ack, the block SHALL go to RESP with resp_error=1 and resp_data=0.
REQ-015 In RESP, resp_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE; a back-to-back request SHALL be accepted no earlier than the IDLE cycle that follows.
REQ-016 Lanes SHALL be little-endian with offset off=addr[1:0]:
- byte: mem_be=4'b0001<<off.
- halfword: mem_be=off[1]?4'b1100:4'b0011.
- word: mem_be=4'b1111.
REQ-017 Store data SHALL be replicated across lanes: byte as {4{wdata[7:0]}}, halfword as {2{wdata[15:0]}}, word unchanged.
REQ-018 Load data SHALL be computed as resp_data=(mem_rdata>>(8*off)), masked to 8 bits for byte, 16 bits for halfword, and 32 bits for word.
REQ-019 For stores, resp_data SHALL be 0.
REQ-020 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_ack outside ACCESS SHALL be ignored.
REQ-021 A mem_ack coincident with timeout expiry SHALL take priority, giving a normal response.

Reset
REQ-022 While reset_n=0, the block SHALL force the FSM to IDLE and drive resp_valid, resp_error, mem_en, mem_we, stall, resp_data, resp_size and the counter to 0 and mem_be to 4'b0000, immediately and asynchronously.
REQ-023 A reset asserted mid-ACCESS SHALL abort the access with no response generated.

Configuration
REQ-024 With MISALIGN_TRAP_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL skip ACCESS (mem_en never asserted) and go IDLE->RESP with resp_error=1 and resp_data=0.
REQ-025 With MISALIGN_TRAP_EN undefined, the offending low address bits SHALL be forced to 0 and the access SHALL proceed normally with no error.

Verification
REQ-026 The bench SHALL check a byte load at addr 0x103 with mem_rdata=0xA1B2C3D4 and ack in the first ACCESS cycle -> mem_be=4'b1000, resp_data=0x000000A1, resp_valid one cycle after the ack.
REQ-027 The bench SHALL check a halfword store at addr 0x202 with wdata=0x0000BEEF -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xBEEFBEEF, mem_we=1 until ack.
REQ-028 The bench SHALL check a word load with mem_ack held low for 16 cycles -> resp_error=1, resp_data=0, FSM back in IDLE.
REQ-029 The bench SHALL check a word load at addr 0x301 with MISALIGN_TRAP_EN defined -> no mem_en, resp_error=1; with the macro undefined -> mem_addr=0x300, mem_be=4'b1111, no error.
REQ-030 The bench SHALL check reset_n driven low mid-ACCESS -> mem_en=0 immediately, no resp_valid, req_ready=1 after release.
